// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry
//   Keypad front end for the ATM controller. Debounces the raw key-down level
//   from the scanner and converts each accepted press into the controller's
//   digit protocol: PIN digits on digito/digito_stb, and a decimal-accumulated
//   amount on monto/monto_stb.
//
//   Optional feature macro: KEYPAD_DIGIT_COUNT_EN adds the cuenta_digitos output.
//
// Ports
//   clk             in   1   system clock, rising edge
//   reset           in   1   asynchronous, active-low reset
//   key_pressed     in   1   raw key-down level, may bounce
//   key_code        in   4   0-9 digit, 10 ENTER, 11 CLEAR, 12 CANCEL, 13-15 unused
//   modo_monto      in   1   0 = PIN entry, 1 = amount entry
//   digito          out  5   last PIN digit, held between strobes
//   digito_stb      out  1   one-cycle pulse, new PIN digit
//   monto           out  32  last confirmed amount, held between strobes
//   monto_stb       out  1   one-cycle pulse, new amount
//   cancelar        out  1   one-cycle pulse, CANCEL accepted
//   tecla_invalida  out  1   one-cycle pulse, key accepted but rejected
//   cuenta_digitos  out  4   (KEYPAD_DIGIT_COUNT_EN only) digit count
//   estado_dbg      out  2   debounce FSM state, for observation only
//
// Handshake: every *_stb / pulse output is high for exactly the one cycle after
// the clock edge that accepted the press; no ready/back-pressure exists, the
// consumer must take the value in that cycle. Data outputs hold between pulses.
module atm_keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_pressed,
    input  logic [3:0]  key_code,
    input  logic        modo_monto,
    output logic [4:0]  digito,
    output logic        digito_stb,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic        cancelar,
    output logic        tecla_invalida,
`ifdef KEYPAD_DIGIT_COUNT_EN
    output logic [3:0]  cuenta_digitos,
`endif
    output logic [1:0]  estado_dbg
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {REPOSO, PRESION, SOSTENIDA, LIBERA} estado_t;

    estado_t        estado_q;
    logic [CW-1:0]  cnt_q, cnt_inc;
    logic           modo_q;
    logic [31:0]    acc_q, acc_d, acc_base, acc_x10;
    logic [3:0]     ndig_q, ndig_d, ndig_base;
    logic [4:0]     digito_q, digito_d;
    logic [31:0]    monto_q, monto_d;
    logic           dstb_q, dstb_d, mstb_q, mstb_d;
    logic           cancel_q, cancel_d, inv_q, inv_d;
    logic           mode_chg, accept, release_done;
`ifdef KEYPAD_DIGIT_COUNT_EN
    logic [1:0]     pin_cnt_q, pin_cnt_d, pin_base;
`endif

    // The counter is zero whenever the FSM sits in REPOSO or SOSTENIDA, so the
    // same increment-and-compare serves the first and every later sample.
    always_comb begin
        cnt_inc      = cnt_q + CW'(1);
        accept       = 1'b0;
        release_done = 1'b0;
        if ((estado_q == REPOSO || estado_q == PRESION) && key_pressed)
            accept = (cnt_inc == CW'(DEBOUNCE_CYCLES));
        if ((estado_q == SOSTENIDA || estado_q == LIBERA) && !key_pressed)
            release_done = (cnt_inc == CW'(DEBOUNCE_CYCLES));
    end

    // Event decode. A mode change clears the accumulator first, so an event
    // accepted in the same cycle works on the cleared state in the new mode.
    always_comb begin
        mode_chg  = (modo_monto != modo_q);
        acc_base  = mode_chg ? 32'd0 : acc_q;
        ndig_base = mode_chg ? 4'd0  : ndig_q;
        acc_x10   = (acc_base << 3) + (acc_base << 1) + {28'd0, key_code};
        acc_d     = acc_base;
        ndig_d    = ndig_base;
        digito_d  = digito_q;
        monto_d   = monto_q;
        dstb_d    = 1'b0;
        mstb_d    = 1'b0;
        cancel_d  = 1'b0;
        inv_d     = 1'b0;
`ifdef KEYPAD_DIGIT_COUNT_EN
        pin_base  = mode_chg ? 2'd0 : pin_cnt_q;
        pin_cnt_d = pin_base;
`endif
        if (accept) begin
            if (!modo_monto) begin
                if (key_code <= 4'd9) begin
                    digito_d = {1'b0, key_code};
                    dstb_d   = 1'b1;
`ifdef KEYPAD_DIGIT_COUNT_EN
                    pin_cnt_d = pin_base + 2'd1;
`endif
                end else if (key_code == 4'd12) begin
                    cancel_d = 1'b1;
`ifdef KEYPAD_DIGIT_COUNT_EN
                    pin_cnt_d = 2'd0;
`endif
                end else begin
                    inv_d = 1'b1;
                end
            end else begin
                if (key_code <= 4'd9) begin
                    if (ndig_base < 4'(MAX_DIGITS)) begin
                        acc_d  = acc_x10;
                        ndig_d = ndig_base + 4'd1;
                    end else begin
                        inv_d = 1'b1;
                    end
                end else if (key_code == 4'd10) begin
                    if (acc_base != 32'd0) begin
                        monto_d = acc_base;
                        mstb_d  = 1'b1;
                        acc_d   = 32'd0;
                        ndig_d  = 4'd0;
                    end else begin
                        inv_d = 1'b1;
                    end
                end else if (key_code == 4'd11) begin
                    acc_d  = 32'd0;
                    ndig_d = 4'd0;
                end else if (key_code == 4'd12) begin
                    acc_d    = 32'd0;
                    ndig_d   = 4'd0;
                    cancel_d = 1'b1;
                end else begin
                    inv_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            modo_q    <= 1'b0;
            acc_q     <= 32'd0;
            ndig_q    <= 4'd0;
            digito_q  <= 5'd0;
            monto_q   <= 32'd0;
            dstb_q    <= 1'b0;
            mstb_q    <= 1'b0;
            cancel_q  <= 1'b0;
            inv_q     <= 1'b0;
`ifdef KEYPAD_DIGIT_COUNT_EN
            pin_cnt_q <= 2'd0;
`endif
        end else begin
            modo_q    <= modo_monto;
            acc_q     <= acc_d;
            ndig_q    <= ndig_d;
            digito_q  <= digito_d;
            monto_q   <= monto_d;
            dstb_q    <= dstb_d;
            mstb_q    <= mstb_d;
            cancel_q  <= cancel_d;
            inv_q     <= inv_d;
`ifdef KEYPAD_DIGIT_COUNT_EN
            pin_cnt_q <= pin_cnt_d;
`endif
            case (estado_q)
                REPOSO, PRESION: begin
                    if (!key_pressed) begin
                        estado_q <= REPOSO;
                        cnt_q    <= '0;
                    end else if (accept) begin
                        estado_q <= SOSTENIDA;
                        cnt_q    <= '0;
                    end else begin
                        estado_q <= PRESION;
                        cnt_q    <= cnt_inc;
                    end
                end
                SOSTENIDA, LIBERA: begin
                    if (key_pressed) begin
                        estado_q <= SOSTENIDA;
                        cnt_q    <= '0;
                    end else if (release_done) begin
                        estado_q <= REPOSO;
                        cnt_q    <= '0;
                    end else begin
                        estado_q <= LIBERA;
                        cnt_q    <= cnt_inc;
                    end
                end
                default: begin
                    estado_q <= REPOSO;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign digito         = digito_q;
    assign digito_stb     = dstb_q;
    assign monto          = monto_q;
    assign monto_stb      = mstb_q;
    assign cancelar       = cancel_q;
    assign tecla_invalida = inv_q;
    assign estado_dbg     = estado_q;
`ifdef KEYPAD_DIGIT_COUNT_EN
    assign cuenta_digitos = modo_q ? ndig_q : {2'b00, pin_cnt_q};
`endif

endmodule

// File: tb/tb_atm_keypad_entry.sv
module tb_atm_keypad_entry;
  localparam int DEB = 4;
  localparam int MAXD = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_pressed;
  logic [3:0]  key_code;
  logic        modo_monto;
  logic [4:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        cancelar;
  logic        tecla_invalida;
  logic [1:0]  estado_dbg;
`ifdef KEYPAD_DIGIT_COUNT_EN
  logic [3:0]  cuenta_digitos;
`endif

  atm_keypad_entry #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .reset(reset), .key_pressed(key_pressed), .key_code(key_code),
    .modo_monto(modo_monto), .digito(digito), .digito_stb(digito_stb),
    .monto(monto), .monto_stb(monto_stb), .cancelar(cancelar),
    .tecla_invalida(tecla_invalida),
`ifdef KEYPAD_DIGIT_COUNT_EN
    .cuenta_digitos(cuenta_digitos),
`endif
    .estado_dbg(estado_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // bookkeeping
  int errors = 0;
  int checks = 0;
  int n_dstb = 0, n_mstb = 0, n_cancel = 0, n_inv = 0;
  logic [31:0] exp_q[$];

  // reference model: debounce as "run of samples disagreeing with the
  // accepted key level"; amount as a plain decimal number with a digit count
  logic        m_down;
  int          m_run;
  logic        m_modo_prev;
  logic [31:0] m_acc;
  int          m_ndig;
  logic [4:0]  m_digito;
  logic [31:0] m_monto;
  logic        m_dstb, m_mstb, m_cancel, m_inv;
  int          m_pin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_down = 1'b0; m_run = 0; m_modo_prev = 1'b0; m_acc = 0; m_ndig = 0;
    m_digito = 0; m_monto = 0; m_dstb = 0; m_mstb = 0; m_cancel = 0; m_inv = 0;
    m_pin = 0;
  endtask

  task automatic model_key(input int k);
    if (!modo_monto) begin
      if (k <= 9) begin m_digito = 5'(k); m_dstb = 1; m_pin = (m_pin + 1) % 4; end
      else if (k == 12) begin m_cancel = 1; m_pin = 0; end
      else m_inv = 1;
    end else begin
      if (k <= 9) begin
        if (m_ndig < MAXD) begin m_acc = m_acc * 10 + 32'(k); m_ndig++; end
        else m_inv = 1;
      end else if (k == 10) begin
        if (m_acc != 0) begin
          m_monto = m_acc; m_mstb = 1; exp_q.push_back(m_acc); m_acc = 0; m_ndig = 0;
        end else m_inv = 1;
      end else if (k == 11) begin m_acc = 0; m_ndig = 0; end
      else if (k == 12) begin m_acc = 0; m_ndig = 0; m_cancel = 1; end
      else m_inv = 1;
    end
  endtask

  task automatic model_edge();
    if (!reset) begin model_reset(); return; end
    m_dstb = 0; m_mstb = 0; m_cancel = 0; m_inv = 0;
    if (modo_monto != m_modo_prev) begin m_acc = 0; m_ndig = 0; m_pin = 0; end
    m_modo_prev = modo_monto;
    if (key_pressed != m_down) m_run++; else m_run = 0;
    if (m_run == DEB) begin
      m_down = ~m_down;
      m_run = 0;
      if (m_down) model_key(int'(key_code));
    end
  endtask

  task automatic check_all();
    chk("digito", 32'(digito), 32'(m_digito));
    chk("digito_stb", 32'(digito_stb), 32'(m_dstb));
    chk("monto", monto, m_monto);
    chk("monto_stb", 32'(monto_stb), 32'(m_mstb));
    chk("cancelar", 32'(cancelar), 32'(m_cancel));
    chk("tecla_invalida", 32'(tecla_invalida), 32'(m_inv));
`ifdef KEYPAD_DIGIT_COUNT_EN
    chk("cuenta_digitos", 32'(cuenta_digitos), m_modo_prev ? 32'(m_ndig) : 32'(m_pin));
`endif
    if (monto_stb === 1'b1) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_monto", monto, exp_q.pop_front());
    end
    if (digito_stb === 1'b1) n_dstb++;
    if (monto_stb === 1'b1) n_mstb++;
    if (cancelar === 1'b1) n_cancel++;
    if (tecla_invalida === 1'b1) n_inv++;
  endtask

  // one clock: model updates on the edge, DUT sampled 1ns later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int bounce);
    key_code = k;
    for (int b = 0; b < bounce; b++) begin
      key_pressed = 1'b1; repeat ($urandom_range(1, 3)) tick();
      key_pressed = 1'b0; tick();
    end
    key_pressed = 1'b1; repeat (hold) tick();
    for (int b = 0; b < bounce; b++) begin
      key_pressed = 1'b0; repeat ($urandom_range(1, 3)) tick();
      key_pressed = 1'b1; tick();
    end
    key_pressed = 1'b0; repeat (DEB + 1) tick();
  endtask

  initial begin
    int base_d, base_i, base_c;
    int r;
    logic [3:0] k;

    reset = 1'b0; key_pressed = 1'b0; key_code = 4'd0; modo_monto = 1'b0;
    model_reset();
    repeat (2) tick();
    chk("rst_digito", 32'(digito), 32'd0);
    chk("rst_monto", monto, 32'd0);
    reset = 1'b1;
    tick();

    // 1: clean PIN press of 7, strobe right after the 4th high edge
    key_code = 4'd7; key_pressed = 1'b1;
    repeat (3) tick();
    chk("t1_early_stb", 32'(digito_stb), 32'd0);
    tick();
    chk("t1_stb", 32'(digito_stb), 32'd1);
    chk("t1_digito", 32'(digito), 32'd7);
    tick();
    chk("t1_stb_drop", 32'(digito_stb), 32'd0);
    key_pressed = 1'b0; repeat (DEB + 1) tick();

    // 2: bounce 3 high, 1 low, 4 high, then hold 50 more
    base_d = n_dstb;
    key_code = 4'd3;
    key_pressed = 1'b1; repeat (3) tick();
    key_pressed = 1'b0; tick();
    key_pressed = 1'b1; repeat (3) tick();
    chk("t2_no_early", 32'(n_dstb - base_d), 32'd0);
    tick();
    chk("t2_stb", 32'(digito_stb), 32'd1);
    repeat (50) tick();
    key_pressed = 1'b0; repeat (DEB + 1) tick();
    chk("t2_one_stb", 32'(n_dstb - base_d), 32'd1);

    // 3: amount 1250, then ENTER on empty accumulator
    modo_monto = 1'b1; repeat (2) tick();
    press(4'd1, 4, 0); press(4'd2, 4, 0); press(4'd5, 4, 0); press(4'd0, 4, 0);
    press(4'd10, 4, 0);
    chk("t3_monto", monto, 32'd1250);
    base_i = n_inv;
    press(4'd10, 4, 0);
    chk("t3_inv", 32'(n_inv - base_i), 32'd1);
    chk("t3_monto_hold", monto, 32'd1250);

    // 4: ten nines, tenth rejected
    base_i = n_inv;
    for (int i = 0; i < 10; i++) press(4'd9, 4, 0);
    chk("t4_inv", 32'(n_inv - base_i), 32'd1);
    press(4'd10, 4, 0);
    chk("t4_monto", monto, 32'd999999999);

    // 5: CLEAR, then mode toggle discards a pending digit
    press(4'd4, 4, 0); press(4'd2, 4, 0); press(4'd11, 4, 0); press(4'd8, 4, 0);
    press(4'd10, 4, 0);
    chk("t5_monto", monto, 32'd8);
    press(4'd3, 4, 0);
    modo_monto = 1'b0; repeat (2) tick();
    modo_monto = 1'b1; repeat (2) tick();
    base_i = n_inv;
    press(4'd10, 4, 0);
    chk("t5_inv", 32'(n_inv - base_i), 32'd1);
    chk("t5_monto_hold", monto, 32'd8);

    // 6: async reset while held, then CANCEL in PIN mode
    key_code = 4'd3; key_pressed = 1'b1; repeat (6) tick();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_async_digito", 32'(digito), 32'd0);
    chk("t6_async_monto", monto, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (DEB + 3) tick();
    key_pressed = 1'b0; repeat (DEB + 1) tick();
    modo_monto = 1'b0; repeat (2) tick();
    base_d = n_dstb; base_c = n_cancel;
    press(4'd12, 4, 0);
    chk("t6_cancel", 32'(n_cancel - base_c), 32'd1);
    chk("t6_no_digit", 32'(n_dstb - base_d), 32'd0);

    // randomized presses with bounce and mode flips
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        modo_monto = ~modo_monto;
        if ($urandom_range(0, 1) == 1) tick();
      end
      r = $urandom_range(0, 19);
      if (r < 12) k = 4'(r % 10);
      else k = 4'($urandom_range(10, 15));
      press(k, $urandom_range(2, 10), $urandom_range(0, 2));
    end

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
